// File: rtl/mdu.sv
// mdu: MIPS multiply/divide unit with HI/LO registers and a busy flag.
// Results are computed when an operation is accepted and held in pend_hi/pend_lo
// until the down-counter expires, so HI/LO keep their old values while busy.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        md_clk,
  input  logic        md_reset,
  input  logic [31:0] md_rs,
  input  logic [31:0] md_rt,
  input  logic [2:0]  md_op,
  input  logic        md_start,
  output logic        md_busy,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW_RAW     = $clog2(MAX_CYCLES + 1);
  localparam int CW         = (CW_RAW < 4) ? 4 : CW_RAW;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_valid;

  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [63:0] sa64;
  logic signed [63:0] sb64;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic [63:0]        res;
  logic               res_valid;

  assign sa   = md_rs;
  assign sb   = md_rt;
  assign sa64 = {{32{md_rs[31]}}, md_rs};
  assign sb64 = {{32{md_rt[31]}}, md_rt};

  // 64-bit {HI,LO} result of the operation presented on md_op; invalid for divide by zero
  always_comb begin
    res       = '0;
    res_valid = 1'b1;
    sq        = '0;
    sr        = '0;
    case (md_op)
      3'd0: res = sa64 * sb64;
      3'd1: res = {32'h0, md_rs} * {32'h0, md_rt};
      3'd2: begin
        if (md_rt == 32'h0) begin
          res_valid = 1'b0;
        end else if (md_rs == 32'h8000_0000 && md_rt == 32'hFFFF_FFFF) begin
          // overflow case handled explicitly so 32-bit signed division never overflows
          res = {32'h0, 32'h8000_0000};
        end else begin
          sq  = sa / sb;
          sr  = sa % sb;
          res = {sr, sq};
        end
      end
      3'd3: begin
        if (md_rt == 32'h0) begin
          res_valid = 1'b0;
        end else begin
          res = {md_rs % md_rt, md_rs / md_rt};
        end
      end
      default: res_valid = 1'b0;
    endcase
  end

  // control FSM, counter, pending result and HI/LO registers
  always_ff @(posedge md_clk) begin
    if (md_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_hi    <= '0;
      pend_lo    <= '0;
      pend_valid <= 1'b0;
      md_busy    <= 1'b0;
      md_hi      <= '0;
      md_lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
            case (md_op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                pend_hi    <= res[63:32];
                pend_lo    <= res[31:0];
                pend_valid <= res_valid;
                cnt        <= md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                md_busy    <= 1'b1;
                state      <= RUN;
              end
              3'd4: md_hi <= md_rs;
              3'd5: md_lo <= md_rs;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (pend_valid) begin
              md_hi <= pend_hi;
              md_lo <= pend_lo;
            end
            md_busy <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
